maze_bg_renderer: RTL

- Parametrised full-screen maze background renderer. Stretches one of NUM_MAZES stored maze images (IMG_W x IMG_H palette indices) across a SCREEN_W x SCREEN_H display.
- Uses incremental scaling counters instead of multiply/divide.
- Maze ROM and palette sit outside the block: it drives the ROM address and takes the palette RGB back.
- Adds frame-synchronised maze switching with a fade-out / fade-in transition. Sits between the VGA controller and the colour mapper.

---
 rtl/maze_bg_renderer_if.sv | 27 ++
 rtl/maze_bg_renderer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_bg_renderer_if.sv
// Maze ROM / palette bus between the background renderer and the external
// synchronous maze ROM plus combinational palette.
//   rom_address : registered ROM read address (renderer -> ROM)
//   rom_q       : palette index returned by the ROM one cycle later
//   pal_index   : palette lookup index (renderer -> palette)
//   pal_red/green/blue : palette colour for pal_index (palette -> renderer)
interface maze_bg_renderer_if #(
    parameter int unsigned ADDR_W  = 15,
    parameter int unsigned PAL_IDX = 4
);
    logic [ADDR_W-1:0]  rom_address;
    logic [PAL_IDX-1:0] rom_q;
    logic [PAL_IDX-1:0] pal_index;
    logic [3:0]         pal_red;
    logic [3:0]         pal_green;
    logic [3:0]         pal_blue;

    modport master (
        output rom_address, pal_index,
        input  rom_q, pal_red, pal_green, pal_blue
    );

    modport slave (
        input  rom_address, pal_index,
        output rom_q, pal_red, pal_green, pal_blue
    );
endinterface

// File: rtl/maze_bg_renderer.sv
// Full-screen maze background renderer. Stretches one of NUM_MAZES stored
// IMG_W x IMG_H maze images over a SCREEN_W x SCREEN_H display using
// incremental scaling counters, and switches mazes on frame boundaries with
// a fade-out / fade-in transition.
// Ports:
//   vga_clk, reset_n   : pixel clock, asynchronous active-low reset
//   DrawX, DrawY, blank: pixel position and visible flag from the VGA controller
//   maze_req, maze_sel : one-cycle maze switch request and target maze
//   rom_bus            : ROM address / palette index out, ROM data / palette RGB in
//   red, green, blue   : registered pixel colour (3-cycle latency)
//   busy, maze_cur     : transition in progress, maze currently displayed
// Optional: define MAZE_GRID_OVERLAY_EN to overlay a white grid every 8 image cells.
module maze_bg_renderer #(
    parameter int unsigned IMG_W     = 75,
    parameter int unsigned IMG_H     = 60,
    parameter int unsigned SCREEN_W  = 640,
    parameter int unsigned SCREEN_H  = 480,
    parameter int unsigned NUM_MAZES = 4,
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned FADE_STEP = 2,
    parameter int unsigned PAL_IDX   = 4,
    localparam int unsigned SEL_W    = (NUM_MAZES > 1) ? $clog2(NUM_MAZES) : 1
) (
    input  logic                vga_clk,
    input  logic                reset_n,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    input  logic                blank,
    input  logic                maze_req,
    input  logic [SEL_W-1:0]    maze_sel,
    maze_bg_renderer_if.master  rom_bus,
    output logic [3:0]          red,
    output logic [3:0]          green,
    output logic [3:0]          blue,
    output logic                busy,
    output logic [SEL_W-1:0]    maze_cur
);
    localparam int unsigned XI_W = $clog2(IMG_W);
    localparam int unsigned XA_W = $clog2(SCREEN_W + IMG_W);
    localparam int unsigned YI_W = $clog2(IMG_H);
    localparam int unsigned YA_W = $clog2(SCREEN_H + IMG_H);
    localparam int unsigned FC_W = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;

    typedef enum logic [1:0] {IDLE, FADE_OUT, SWAP, FADE_IN} state_t;

    state_t             state, state_n;
    logic [9:0]         prev_x, prev_y;
    logic [XI_W-1:0]    x_idx, x_idx_n;
    logic [XA_W-1:0]    x_acc, x_acc_n, x_sum;
    logic [YI_W-1:0]    y_idx, y_idx_n;
    logic [YA_W-1:0]    y_acc, y_acc_n, y_sum;
    logic [ADDR_W-1:0]  row_base, row_base_n, bank_base;
    logic               x_inc, y_inc, frame_tick, step_due;
    logic [4:0]         level, level_n;
    logic [FC_W-1:0]    fcnt, fcnt_n;
    logic [SEL_W-1:0]   target, target_n, maze_cur_n;
    logic [1:0]         blank_d;
    logic [3:0]         red_n, green_n, blue_n;

    assign rom_bus.pal_index = rom_bus.rom_q;
    assign frame_tick = (DrawY == 10'd0) && (prev_y != 10'd0);
    assign step_due   = (fcnt == FC_W'(FADE_STEP - 1));

    // Horizontal scaling: x_idx tracks floor(DrawX*IMG_W/SCREEN_W) one DrawX step at a time
    always_comb begin
        x_idx_n = x_idx;
        x_acc_n = x_acc;
        x_inc   = 1'b0;
        x_sum   = x_acc + XA_W'(IMG_W);
        if (DrawX != prev_x) begin
            if (DrawX == 10'd0) begin
                x_idx_n = '0;
                x_acc_n = '0;
            end else if (32'(DrawX) < SCREEN_W) begin
                if (x_sum >= XA_W'(SCREEN_W)) begin
                    x_acc_n = x_sum - XA_W'(SCREEN_W);
                    x_inc   = 1'b1;
                end else begin
                    x_acc_n = x_sum;
                end
            end
        end
        if (x_inc) x_idx_n = x_idx + XI_W'(1);
    end

    // Vertical scaling, with row_base following y_idx*IMG_W incrementally
    always_comb begin
        y_idx_n    = y_idx;
        y_acc_n    = y_acc;
        row_base_n = row_base;
        y_inc      = 1'b0;
        y_sum      = y_acc + YA_W'(IMG_H);
        if (DrawY != prev_y) begin
            if (DrawY == 10'd0) begin
                y_idx_n    = '0;
                y_acc_n    = '0;
                row_base_n = '0;
            end else if (32'(DrawY) < SCREEN_H) begin
                if (y_sum >= YA_W'(SCREEN_H)) begin
                    y_acc_n = y_sum - YA_W'(SCREEN_H);
                    y_inc   = 1'b1;
                end else begin
                    y_acc_n = y_sum;
                end
            end
        end
        if (y_inc) begin
            y_idx_n    = y_idx + YI_W'(1);
            row_base_n = row_base + ADDR_W'(IMG_W);
        end
    end

    // Bank base is a constant per maze, so no multiplier is needed
    always_comb begin
        bank_base = '0;
        for (int unsigned i = 0; i < NUM_MAZES; i++) begin
            if (32'(maze_cur) == i) bank_base = ADDR_W'(i * IMG_W * IMG_H);
        end
    end

`ifdef MAZE_GRID_OVERLAY_EN
    logic       grid_n;
    logic [1:0] grid_d;
    assign grid_n = (x_inc && (x_idx_n[2:0] == 3'd0)) || (y_inc && (y_idx_n[2:0] == 3'd0));

    // Grid flag follows the same two-stage delay as blank
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) grid_d <= '0;
        else          grid_d <= {grid_d[0], grid_n};
    end
`endif

    // Fade is an 8-bit product of colour and level, keeping the top nibble
    function automatic logic [3:0] fade(input logic [3:0] c, input logic [4:0] lvl);
        logic [7:0] p;
        p = 8'(c) * 8'(lvl);
        return p[7:4];
    endfunction

    // Output colour: fade, optional grid, then blanking
    always_comb begin
        red_n   = fade(rom_bus.pal_red, level);
        green_n = fade(rom_bus.pal_green, level);
        blue_n  = fade(rom_bus.pal_blue, level);
`ifdef MAZE_GRID_OVERLAY_EN
        if (grid_d[1]) begin
            red_n   = 4'hF;
            green_n = 4'hF;
            blue_n  = 4'hF;
        end
`endif
        if (!blank_d[1]) begin
            red_n   = 4'h0;
            green_n = 4'h0;
            blue_n  = 4'h0;
        end
    end

    // Transition FSM: level steps every FADE_STEP frame ticks; bank swaps on a tick
    always_comb begin
        state_n    = state;
        level_n    = level;
        fcnt_n     = fcnt;
        target_n   = target;
        maze_cur_n = maze_cur;
        case (state)
            IDLE: begin
                level_n = 5'd16;
                fcnt_n  = '0;
                if (maze_req && (maze_sel != maze_cur) && (32'(maze_sel) < NUM_MAZES)) begin
                    target_n = maze_sel;
                    state_n  = FADE_OUT;
                end
            end
            FADE_OUT: begin
                if (frame_tick) begin
                    if (step_due) begin
                        fcnt_n  = '0;
                        level_n = level - 5'd1;
                        if (level == 5'd1) state_n = SWAP;
                    end else begin
                        fcnt_n = fcnt + FC_W'(1);
                    end
                end
            end
            SWAP: begin
                if (frame_tick) begin
                    maze_cur_n = target;
                    fcnt_n     = '0;
                    state_n    = FADE_IN;
                end
            end
            FADE_IN: begin
                if (frame_tick) begin
                    if (step_due) begin
                        fcnt_n  = '0;
                        level_n = level + 5'd1;
                        if (level == 5'd15) state_n = IDLE;
                    end else begin
                        fcnt_n = fcnt + FC_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            level    <= 5'd16;
            fcnt     <= '0;
            target   <= '0;
            maze_cur <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            level    <= level_n;
            fcnt     <= fcnt_n;
            target   <= target_n;
            maze_cur <= maze_cur_n;
            busy     <= (state_n != IDLE);
        end
    end

    // Scaling counters, address stage, blank delay and colour stage
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_x              <= '0;
            prev_y              <= '0;
            x_idx               <= '0;
            x_acc               <= '0;
            y_idx               <= '0;
            y_acc               <= '0;
            row_base            <= '0;
            rom_bus.rom_address <= '0;
            blank_d             <= '0;
            red                 <= '0;
            green               <= '0;
            blue                <= '0;
        end else begin
            prev_x              <= DrawX;
            prev_y              <= DrawY;
            x_idx               <= x_idx_n;
            x_acc               <= x_acc_n;
            y_idx               <= y_idx_n;
            y_acc               <= y_acc_n;
            row_base            <= row_base_n;
            rom_bus.rom_address <= bank_base + row_base_n + ADDR_W'(x_idx_n);
            blank_d             <= {blank_d[0], blank};
            red                 <= red_n;
            green               <= green_n;
            blue                <= blue_n;
        end
    end
endmodule
